// File: rtl/clk_gen_pkg.sv
// =============================================================================
// clk_gen_pkg : shared types, constants and ratio helpers for the divider bank
// Revision    : 1.0
// =============================================================================
`default_nettype none

package clk_gen_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    localparam int unsigned DIV_MIN = 2;

    // Ratios below DIV_MIN collapse to the fastest legal divider.
    function automatic logic [31:0] clamp_ratio(input logic [31:0] d);
        return (d < DIV_MIN) ? 32'(DIV_MIN) : d;
    endfunction

    // ceil(dl/2) without forming dl+1, so the widest ratio cannot overflow.
    function automatic logic [31:0] high_time(input logic [31:0] dl);
        return (dl >> 1) + {31'd0, dl[0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_div_channel.sv
// =============================================================================
// clock_div_channel : one programmable divider (IDLE/RUN FSM, counter, outputs)
// Revision          : 1.0
// =============================================================================
`default_nettype none

module clock_div_channel
    import clk_gen_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);

    ch_state_t        state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] dl, dl_nxt;
    logic             clk_r, clk_nxt;
    logic             tick_r, tick_nxt;

    logic [DIV_W-1:0] div_clamped;
    logic [DIV_W-1:0] high_cnt;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] last_cnt;

    assign div_clamped = DIV_W'(clamp_ratio(32'(div)));
    assign high_cnt    = DIV_W'(high_time(32'(dl)));
    assign cnt_inc     = cnt + 1'b1;
    assign last_cnt    = dl - 1'b1;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            dl     <= DIV_W'(DIV_MIN);
            clk_r  <= 1'b0;
            tick_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            dl     <= dl_nxt;
            clk_r  <= clk_nxt;
            tick_r <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dl_nxt    = dl;
        clk_nxt   = clk_r;
        tick_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                clk_nxt = 1'b0;
                if (en) begin
                    dl_nxt    = div_clamped;
                    clk_nxt   = 1'b1;
                    tick_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt < last_cnt) begin
                    cnt_nxt = cnt_inc;
                    clk_nxt = (cnt_inc < high_cnt);
                end else if (en) begin
                    // Period boundary: ratio is only re-sampled here.
                    dl_nxt   = div_clamped;
                    cnt_nxt  = '0;
                    clk_nxt  = 1'b1;
                    tick_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    clk_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                clk_nxt   = 1'b0;
            end
        endcase
    end

    assign clk_out = clk_r;
    assign tick    = tick_r;
    assign active  = (state == RUN);

endmodule

`default_nettype wire

// File: rtl/clock_divider_bank.sv
// =============================================================================
// clock_divider_bank : NUM_CH independent glitch-free programmable dividers
// Revision           : 1.0
// =============================================================================
`default_nettype none

module clock_divider_bank
    import clk_gen_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*DIV_W-1:0] div,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       active
);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            clock_div_channel #(
                .DIV_W (DIV_W)
            ) u_ch (
                .clk_in  (clk_in),
                .rst_n   (rst_n),
                .en      (en[i]),
                .div     (div[i*DIV_W +: DIV_W]),
                .clk_out (clk_out[i]),
                .tick    (tick[i]),
                .active  (active[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_bank.sv
// =============================================================================
// tb_clock_divider_bank : directed + random checks against a waveform model
// Revision              : 1.0
// =============================================================================
`default_nettype none

module tb_clock_divider_bank;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;

    logic                    clk_in;
    logic                    rst_n;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*DIV_W-1:0] div;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       active;

    int vectors;
    int miscompares;

    // Model: each running channel holds the remaining samples of its period.
    bit                wave [NUM_CH][$];
    bit                run_m [NUM_CH];
    logic [NUM_CH-1:0] exp_clk;
    logic [NUM_CH-1:0] exp_tick;
    logic [NUM_CH-1:0] exp_act;

    clock_divider_bank #(
        .NUM_CH (NUM_CH),
        .DIV_W  (DIV_W)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .div     (div),
        .clk_out (clk_out),
        .tick    (tick),
        .active  (active)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [NUM_CH*DIV_W-1:0] pack2(input int d0, input int d1);
        logic [NUM_CH*DIV_W-1:0] v;
        v = '0;
        v[0 +: DIV_W]     = DIV_W'(d0);
        v[DIV_W +: DIV_W] = DIV_W'(d1);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            wave[c].delete();
            run_m[c] = 1'b0;
        end
        exp_clk  = '0;
        exp_tick = '0;
        exp_act  = '0;
    endtask

    task automatic load(input int c, input int d);
        int len;
        int hi;
        len = (d < 2) ? 2 : d;
        hi  = (len + 1) / 2;
        wave[c].delete();
        for (int k = 0; k < len; k++) wave[c].push_back(k < hi);
        exp_clk[c]  = wave[c].pop_front();
        exp_tick[c] = 1'b1;
        exp_act[c]  = 1'b1;
        run_m[c]    = 1'b1;
    endtask

    task automatic model_edge(input logic [NUM_CH-1:0] e, input logic [NUM_CH*DIV_W-1:0] dv);
        for (int c = 0; c < NUM_CH; c++) begin
            int d;
            d = int'(dv[c*DIV_W +: DIV_W]);
            exp_tick[c] = 1'b0;
            if (!run_m[c]) begin
                if (e[c]) load(c, d);
                else begin
                    exp_clk[c] = 1'b0;
                    exp_act[c] = 1'b0;
                end
            end else if (wave[c].size() == 0) begin
                if (e[c]) load(c, d);
                else begin
                    run_m[c]   = 1'b0;
                    exp_clk[c] = 1'b0;
                    exp_act[c] = 1'b0;
                end
            end else begin
                exp_clk[c] = wave[c].pop_front();
            end
        end
    endtask

    task automatic check(input string tag);
        vectors++;
        assert (clk_out === exp_clk) else begin
            miscompares++;
            $error("FAIL %s clk_out: got %b expected %b", tag, clk_out, exp_clk);
        end
        vectors++;
        assert (tick === exp_tick) else begin
            miscompares++;
            $error("FAIL %s tick: got %b expected %b", tag, tick, exp_tick);
        end
        vectors++;
        assert (active === exp_act) else begin
            miscompares++;
            $error("FAIL %s active: got %b expected %b", tag, active, exp_act);
        end
    endtask

    task automatic step(input logic [NUM_CH-1:0] e, input logic [NUM_CH*DIV_W-1:0] dv,
                        input string tag);
        en  = e;
        div = dv;
        @(posedge clk_in);
        model_edge(e, dv);
        #1;
        check(tag);
    endtask

    task automatic idle_out(input int n);
        for (int k = 0; k < n; k++) step('0, pack2(2, 2), "drain");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();

        // Reset holds everything low even with enables asserted.
        rst_n = 1'b0;
        en    = '1;
        div   = pack2(4, 4);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_in);
            #1;
            check("reset_hold");
        end
        #2 rst_n = 1'b1;

        // Even ratio on ch0: 1100 repeating.
        for (int k = 0; k < 20; k++) step(2'b01, pack2(4, 0), "even_d4");
        idle_out(6);

        // Odd ratio and clamp.
        for (int k = 0; k < 15; k++) step(2'b01, pack2(5, 0), "odd_d5");
        idle_out(7);
        for (int k = 0; k < 8; k++) step(2'b01, pack2(0, 0), "clamp_d0");
        for (int k = 0; k < 8; k++) step(2'b01, pack2(1, 0), "clamp_d1");
        for (int k = 0; k < 8; k++) step(2'b01, pack2(2, 0), "clamp_d2");
        idle_out(4);

        // Ratio change at cnt=1 only takes effect at the boundary.
        step(2'b01, pack2(4, 0), "chg_start");
        step(2'b01, pack2(4, 0), "chg_cnt1");
        for (int k = 0; k < 16; k++) step(2'b01, pack2(6, 0), "chg_d6");
        idle_out(8);

        // Disable at cnt=2 completes the 8-cycle period.
        for (int k = 0; k < 3; k++) step(2'b01, pack2(8, 0), "dis_start");
        for (int k = 0; k < 12; k++) step(2'b00, pack2(8, 0), "dis_drain");

        // en low then high inside a period does not stop the channel.
        for (int k = 0; k < 3; k++) step(2'b01, pack2(8, 0), "glitch_en");
        for (int k = 0; k < 2; k++) step(2'b00, pack2(8, 0), "glitch_low");
        for (int k = 0; k < 12; k++) step(2'b01, pack2(8, 0), "glitch_high");
        idle_out(10);

        // Asynchronous reset at cnt=3 clears outputs without waiting for an edge.
        for (int k = 0; k < 4; k++) step(2'b01, pack2(8, 0), "rst_run");
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst");
        #2 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) step(2'b01, pack2(8, 0), "rst_restart");
        idle_out(10);

        // Channel independence: ch1 stopped while ch0 keeps running.
        for (int k = 0; k < 14; k++) step(2'b11, pack2(3, 7), "indep_both");
        for (int k = 0; k < 28; k++) step(2'b01, pack2(3, 7), "indep_ch0");
        idle_out(10);

        // Widest ratio: one full period plus a boundary, no wrap-around.
        for (int k = 0; k < 260; k++) step(2'b01, pack2(255, 0), "max_ratio");
        idle_out(260);

        // Random enables and ratios on both channels.
        begin
            logic [NUM_CH-1:0] e;
            int d0, d1;
            e  = '0;
            d0 = 0;
            d1 = 0;
            for (int k = 0; k < 600; k++) begin
                for (int c = 0; c < NUM_CH; c++)
                    if ($urandom_range(0, 9) == 0) e[c] = ~e[c];
                if ($urandom_range(0, 3) == 0) d0 = $urandom_range(0, 12);
                if ($urandom_range(0, 3) == 0) d1 = $urandom_range(0, 12);
                step(e, pack2(d0, d1), "random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
